fan_output_collector: RTL and testbench

- Sits directly downstream of flexdpe and consumes its reduction-network outputs (o_data_valid, o_data_bus).
- Each cycle flexdpe may present up to NUM_PES sparse valid 32-bit partial/final sums. This block buffers those vectors and compacts them into a dense one-result-per-cycle stream with valid/ready handshake, tagged with source lane.
- flexdpe has no backpressure, so this block reports near-full and flags lost vectors.

---
 rtl/fan_output_collector.sv | 133 +++++++++++++
 tb/tb_fan_output_collector.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fan_output_collector.sv
`default_nettype none
// ============================================================================
// Module   : fan_output_collector
// Purpose  : Buffers sparse flexdpe result vectors and compacts them into a
//            dense, lane-tagged, valid/ready beat stream.
//            Optional macro FAN_COLLECT_ZERO_SKIP_EN drops +/-0.0 lanes at push.
// Revision : 1.0 - initial release
// ============================================================================
module fan_output_collector #(
    parameter int OUT_DATA_TYPE = 32,
    parameter int NUM_PES       = 16,
    parameter int LOG2_PES      = 4,
    parameter int DEPTH         = 4,
    parameter int LOG2_DEPTH    = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_PES-1:0]                 i_data_valid,
    input  logic [NUM_PES*OUT_DATA_TYPE-1:0]   i_data_bus,
    output logic                               o_almost_full,
    output logic                               o_overflow,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic [OUT_DATA_TYPE-1:0]           o_data,
    output logic [LOG2_PES-1:0]                o_lane,
    output logic                               o_last,
    output logic                               o_empty
);

    localparam int                    CNT_W    = LOG2_DEPTH + 1;
    localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      AF_CNT   = CNT_W'(DEPTH - 1);
    localparam logic [LOG2_DEPTH-1:0] PTR_ONE  = LOG2_DEPTH'(1);
    localparam logic [NUM_PES-1:0]    MASK_ONE = NUM_PES'(1);

    logic [NUM_PES-1:0]               mask_q [DEPTH];
    logic [NUM_PES*OUT_DATA_TYPE-1:0] data_q [DEPTH];
    logic [LOG2_DEPTH-1:0]            rd_ptr_q;
    logic [LOG2_DEPTH-1:0]            wr_ptr_q;
    logic [CNT_W-1:0]                 count_q;
    logic [CNT_W-1:0]                 count_d;
    logic                             ovf_q;
    logic                             af_q;

    logic [NUM_PES-1:0]               in_mask;
    logic [NUM_PES-1:0]               head_mask;
    logic [NUM_PES*OUT_DATA_TYPE-1:0] head_vec;
    logic [LOG2_PES-1:0]              sel;
    logic [OUT_DATA_TYPE-1:0]         sel_data;
    logic                             head_one;
    logic                             accept;
    logic                             pop;
    logic                             push;
    logic                             drop;

`ifdef FAN_COLLECT_ZERO_SKIP_EN
    // Sign bit ignored so both +0.0 and -0.0 are treated as zero.
    always_comb begin
        in_mask = '0;
        for (int k = 0; k < NUM_PES; k++) begin
            in_mask[k] = i_data_valid[k] &
                         (i_data_bus[k*OUT_DATA_TYPE +: OUT_DATA_TYPE-1] != '0);
        end
    end
`else
    assign in_mask = i_data_valid;
`endif

    assign head_mask = mask_q[rd_ptr_q];
    assign head_vec  = data_q[rd_ptr_q];

    // Descending scan so the lowest set lane is the last one to win.
    always_comb begin
        sel      = '0;
        sel_data = '0;
        for (int k = NUM_PES - 1; k >= 0; k--) begin
            if (head_mask[k]) begin
                sel      = LOG2_PES'(k);
                sel_data = head_vec[k*OUT_DATA_TYPE +: OUT_DATA_TYPE];
            end
        end
    end

    assign head_one = (head_mask != '0) && ((head_mask & (head_mask - MASK_ONE)) == '0);

    assign o_valid       = (count_q != '0);
    assign o_empty       = (count_q == '0);
    assign o_data        = o_valid ? sel_data : '0;
    assign o_lane        = o_valid ? sel : '0;
    assign o_last        = o_valid & head_one;
    assign o_overflow    = ovf_q;
    assign o_almost_full = af_q;

    assign accept  = o_valid & i_ready;
    assign pop     = accept & o_last;
    assign push    = (|in_mask) & ((count_q < FULL_CNT) | pop);
    assign drop    = (|in_mask) & (count_q == FULL_CNT) & ~pop;
    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            af_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mask_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                mask_q[rd_ptr_q][sel] <= 1'b0;
            end
            // Placed after the clear: when full with a pop, wr_ptr == rd_ptr
            // and the incoming vector must overwrite the retiring entry.
            if (push) begin
                mask_q[wr_ptr_q] <= in_mask;
                data_q[wr_ptr_q] <= i_data_bus;
                wr_ptr_q         <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
            count_q <= count_d;
            af_q    <= (count_d >= AF_CNT);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fan_output_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_fan_output_collector
// Purpose  : Directed vector table plus hand sequences for fan_output_collector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fan_output_collector;

    localparam int W  = 32;
    localparam int NP = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NP-1:0]     dv  = '0;
    logic [NP*W-1:0]   bus = '0;
    logic              rdy = 1'b0;
    logic              o_almost_full, o_overflow, o_valid, o_last, o_empty;
    logic [W-1:0]      o_data;
    logic [3:0]        o_lane;

    int n_cmp = 0;
    int n_err = 0;

    fan_output_collector dut (
        .clk           (clk),
        .rst           (rst),
        .i_data_valid  (dv),
        .i_data_bus    (bus),
        .o_almost_full (o_almost_full),
        .o_overflow    (o_overflow),
        .o_valid       (o_valid),
        .i_ready       (rdy),
        .o_data        (o_data),
        .o_lane        (o_lane),
        .o_last        (o_last),
        .o_empty       (o_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] mask;
        logic [31:0] base;
        logic        ready;
        logic        e_valid;
        logic [31:0] e_data;
        logic [3:0]  e_lane;
        logic        e_last;
        logic        e_empty;
        logic        e_af;
        logic        e_ovf;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] d,
                           input logic [3:0] l, input logic last, input logic emp,
                           input logic af, input logic ovf);
        chk({tag, ".valid"}, 32'(o_valid), 32'(v));
        chk({tag, ".data"}, o_data, d);
        chk({tag, ".lane"}, 32'(o_lane), 32'(l));
        chk({tag, ".last"}, 32'(o_last), 32'(last));
        chk({tag, ".empty"}, 32'(o_empty), 32'(emp));
        chk({tag, ".afull"}, 32'(o_almost_full), 32'(af));
        chk({tag, ".ovf"}, 32'(o_overflow), 32'(ovf));
    endtask

    task automatic fill(input logic [31:0] base);
        for (int k = 0; k < NP; k++) bus[k*W +: W] = base + 32'(k);
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1ns later.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick(); rst = 1'b0; dv = '0; rdy = 1'b0;
        tick(); tick(); rst = 1'b1;
    endtask

    vec_t tbl [18];
    int   beats;

    initial begin
        //          mask     base      rdy v  data      lane last emp af ovf
        tbl[0]  = '{16'h0000, 32'h0,    0, 0, 32'h0,    0, 0, 1, 0, 0};
        tbl[1]  = '{16'h0005, 32'h100,  1, 0, 32'h0,    0, 0, 1, 0, 0};
        tbl[2]  = '{16'h0000, 32'h0,    1, 1, 32'h100,  0, 0, 0, 0, 0};
        tbl[3]  = '{16'h0000, 32'h0,    1, 1, 32'h102,  2, 1, 0, 0, 0};
        tbl[4]  = '{16'h0000, 32'h0,    0, 0, 32'h0,    0, 0, 1, 0, 0};
        tbl[5]  = '{16'h0001, 32'h200,  0, 0, 32'h0,    0, 0, 1, 0, 0};
        tbl[6]  = '{16'h0001, 32'h300,  0, 1, 32'h200,  0, 1, 0, 0, 0};
        tbl[7]  = '{16'h0001, 32'h400,  0, 1, 32'h200,  0, 1, 0, 0, 0};
        tbl[8]  = '{16'h0001, 32'h500,  0, 1, 32'h200,  0, 1, 0, 1, 0};
        tbl[9]  = '{16'h0001, 32'h600,  0, 1, 32'h200,  0, 1, 0, 1, 0};
        tbl[10] = '{16'h0000, 32'h0,    0, 1, 32'h200,  0, 1, 0, 1, 1};
        tbl[11] = '{16'h0003, 32'h700,  1, 1, 32'h200,  0, 1, 0, 1, 1};
        tbl[12] = '{16'h0000, 32'h0,    1, 1, 32'h300,  0, 1, 0, 1, 1};
        tbl[13] = '{16'h0000, 32'h0,    1, 1, 32'h400,  0, 1, 0, 1, 1};
        tbl[14] = '{16'h0000, 32'h0,    1, 1, 32'h500,  0, 1, 0, 0, 1};
        tbl[15] = '{16'h0000, 32'h0,    1, 1, 32'h700,  0, 0, 0, 0, 1};
        tbl[16] = '{16'h0000, 32'h0,    1, 1, 32'h701,  1, 1, 0, 0, 1};
        tbl[17] = '{16'h0000, 32'h0,    1, 0, 32'h0,    0, 0, 1, 0, 1};

        do_reset();
        foreach (tbl[i]) begin
            tick();
            dv = tbl[i].mask; fill(tbl[i].base); rdy = tbl[i].ready;
            #1;
            chk_out($sformatf("row%0d", i), tbl[i].e_valid, tbl[i].e_data, tbl[i].e_lane,
                    tbl[i].e_last, tbl[i].e_empty, tbl[i].e_af, tbl[i].e_ovf);
        end

        // Single vector with FP32 payloads.
        do_reset();
        tick(); bus = '0; bus[0*W +: W] = 32'h41000000; bus[2*W +: W] = 32'h40400000;
        dv = 16'h0005; rdy = 1'b1;
        tick(); dv = '0; #1; chk_out("single.b1", 1, 32'h41000000, 0, 0, 0, 0, 0);
        tick(); #1;          chk_out("single.b2", 1, 32'h40400000, 2, 1, 0, 0, 0);
        tick(); #1;          chk_out("single.end", 0, 32'h0, 0, 0, 1, 0, 0);

        // Backpressure: head must hold steady while stalled.
        tick(); bus = '0; bus[0*W +: W] = 32'h3F800000; bus[15*W +: W] = 32'h40000000;
        dv = 16'h8001; rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick(); dv = '0; #1;
            chk_out($sformatf("stall%0d", c), 1, 32'h3F800000, 0, 0, 0, 0, 0);
        end
        tick(); rdy = 1'b1; #1; chk_out("bp.b1", 1, 32'h3F800000, 0, 0, 0, 0, 0);
        tick(); #1;             chk_out("bp.b2", 1, 32'h40000000, 15, 1, 0, 0, 0);
        tick(); #1;             chk_out("bp.end", 0, 32'h0, 0, 0, 1, 0, 0);

        // Full buffer with a same-cycle pop and push: accepted, no overflow.
        do_reset();
        fill(32'h900); rdy = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick(); dv = 16'h0001;
        end
        tick(); dv = 16'h0003; rdy = 1'b1; #1;
        chk_out("fullpop.pre", 1, 32'h900, 0, 1, 0, 1, 0);
        tick(); dv = '0; rdy = 1'b0; #1;
        chk_out("fullpop.post", 1, 32'h900, 0, 1, 0, 1, 0);
        beats = 0;
        rdy = 1'b1;
        for (int c = 0; c < 20 && o_valid; c++) begin
            tick(); #1;
            beats++;
        end
        chk("fullpop.beats", 32'(beats), 32'd5);
        chk("fullpop.ovf", 32'(o_overflow), 32'd0);

        // All-zero masks are never stored and never overflow.
        rdy = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick(); dv = '0;
        end
        #1; chk_out("idle", 0, 32'h0, 0, 0, 1, 0, 0);

        // Reset mid-drain, with overflow previously set.
        fill(32'hA00);
        for (int c = 0; c < 5; c++) begin
            tick(); dv = 16'h0001;
        end
        tick(); dv = '0; #1;
        chk_out("rstmid.pre", 1, 32'hA00, 0, 1, 0, 1, 1);
        rst = 1'b0;
        tick(); rst = 1'b1; #1;
        chk_out("rstmid.post", 0, 32'h0, 0, 0, 1, 0, 0);

        // Zero-valued lane handling.
        tick(); bus = '0; bus[1*W +: W] = 32'h41000000; dv = 16'h0003; rdy = 1'b1;
        tick(); dv = '0; #1;
`ifdef FAN_COLLECT_ZERO_SKIP_EN
        chk_out("zskip.b1", 1, 32'h41000000, 1, 1, 0, 0, 0);
`else
        chk_out("zskip.b1", 1, 32'h0, 0, 0, 0, 0, 0);
        tick(); #1;
        chk_out("zskip.b2", 1, 32'h41000000, 1, 1, 0, 0, 0);
`endif
        tick(); #1;
        chk_out("zskip.end", 0, 32'h0, 0, 0, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
